weight_buffer_sched: RTL and testbench

Sequencer that owns one `weight_buffer` instance.
- Per job, it first loads a programmed number of wide words from the weight fetch stream into the buffer.
- It then issues a programmed run of narrow reads starting at a base address.
- It tags the returned data with valid/last for the PE array.
- It sits between the weight DMA stream and the PE-side weight bus, and it is the only master of the buffer's read and write ports.

---
 rtl/weight_buffer_sched_pkg.sv | 23 ++
 rtl/weight_buffer_sched_tag_delay_line.sv | 48 ++++
 rtl/weight_buffer_sched.sv | 163 ++++++++++++++++
 tb/tb_weight_buffer_sched.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_buffer_sched_pkg.sv
// Shared types and helpers for the weight buffer sequencer.
//   state_e    : sequencer FSM states
//   DEF_RD_LAT : default buffer read latency (read_req cycle to read_data cycle)
//   LOG2       : ceil(log2(n)), used to size counters
package weight_buffer_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_READ  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    localparam int DEF_RD_LAT = 3;

    function automatic int LOG2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/weight_buffer_sched_tag_delay_line.sv
// Fixed-depth {valid, last} shift register that tracks reads in flight
// through the weight buffer, so tags line up with the returned data.
//   clk, reset : clock, synchronous active-high clear
//   vld_i      : read issued this cycle
//   last_i     : the issued read is the final one of the job
//   vld_o      : tag valid, DEPTH cycles after vld_i
//   last_o     : last tag, DEPTH cycles after last_i
//   pend_o     : a tag is still travelling (any stage except the output one)
module tag_delay_line #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic vld_i,
    input  logic last_i,
    output logic vld_o,
    output logic last_o,
    output logic pend_o
);

    logic [DEPTH:1] vld_pipe_q;
    logic [DEPTH:1] lst_pipe_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe_q <= '0;
            lst_pipe_q <= '0;
        end else begin
            vld_pipe_q[1] <= vld_i;
            lst_pipe_q[1] <= vld_i & last_i;
            for (int i = 2; i <= DEPTH; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                lst_pipe_q[i] <= lst_pipe_q[i-1];
            end
        end
    end

    // The output stage is excluded: whoever waits on pend_o can finish in
    // the same cycle the final tag is presented.
    always_comb begin
        pend_o = 1'b0;
        for (int i = 1; i < DEPTH; i++) pend_o = pend_o | vld_pipe_q[i];
    end

    assign vld_o  = vld_pipe_q[DEPTH];
    assign last_o = lst_pipe_q[DEPTH];

endmodule

// File: rtl/weight_buffer_sched.sv
// Job sequencer for one weight buffer: loads cfg_fill_words wide words from
// the fill stream, then issues cfg_rd_count narrow reads from cfg_rd_base
// (address wraps), and tags returned data with valid/last for the PEs.
//   cfg_*       : job descriptor handshake, accepted only in IDLE
//   fill_*      : wide fill stream, ready only in FILL
//   wt_stall    : PE backpressure, blocks new read issue only
//   wt_*        : weights to the PE array, done pulses at job end
//   buf_read_*  : narrow read port of the buffer (registered)
//   buf_write_* : wide write port of the buffer (combinational from fill)
module weight_buffer_sched
    import weight_buffer_sched_pkg::*;
#(
    parameter int RD_WIDTH      = 16,
    parameter int WR_WIDTH      = 64,
    parameter int RD_ADDR_WIDTH = 7,
    parameter int WR_ADDR_WIDTH = 5,
    parameter int RD_LAT        = DEF_RD_LAT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [WR_ADDR_WIDTH:0]   cfg_fill_words,
    input  logic [RD_ADDR_WIDTH-1:0] cfg_rd_base,
    input  logic [RD_ADDR_WIDTH:0]   cfg_rd_count,
    input  logic                     fill_valid,
    output logic                     fill_ready,
    input  logic [WR_WIDTH-1:0]      fill_data,
    input  logic                     wt_stall,
    output logic                     wt_valid,
    output logic [RD_WIDTH-1:0]      wt_data,
    output logic                     wt_last,
    output logic                     done,
    output logic                     buf_read_req,
    output logic [RD_ADDR_WIDTH-1:0] buf_read_addr,
    input  logic [RD_WIDTH-1:0]      buf_read_data,
    output logic                     buf_write_req,
    output logic [WR_WIDTH-1:0]      buf_write_data,
    output logic [WR_ADDR_WIDTH-1:0] buf_write_addr
);

    // Counters carry one extra bit so a full buffer (2^W) is representable.
    localparam int FILL_CW = LOG2(2**WR_ADDR_WIDTH) + 1;
    localparam int RD_CW   = LOG2(2**RD_ADDR_WIDTH) + 1;

    state_e                   state_q, state_d;
    logic [FILL_CW-1:0]       fill_words_q, fill_words_d;
    logic [FILL_CW-1:0]       fill_cnt_q, fill_cnt_d;
    logic [RD_ADDR_WIDTH-1:0] rd_base_q, rd_base_d;
    logic [RD_CW-1:0]         rd_count_q, rd_count_d;
    logic [RD_CW-1:0]         idx_q, idx_d;
    logic                     rd_req_q, rd_req_d;
    logic [RD_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                     rd_last_q, rd_last_d;
    logic                     done_q, done_d;
    logic                     fill_hs;
    logic                     tag_pend;

    assign cfg_ready  = (state_q == S_IDLE);
    assign fill_ready = (state_q == S_FILL);
    assign fill_hs    = fill_valid & fill_ready;

    always_comb begin
        state_d      = state_q;
        fill_words_d = fill_words_q;
        fill_cnt_d   = fill_cnt_q;
        rd_base_d    = rd_base_q;
        rd_count_d   = rd_count_q;
        idx_d        = idx_q;
        rd_req_d     = 1'b0;
        rd_addr_d    = rd_addr_q;
        rd_last_d    = 1'b0;
        done_d       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    fill_words_d = cfg_fill_words;
                    rd_base_d    = cfg_rd_base;
                    rd_count_d   = cfg_rd_count;
                    fill_cnt_d   = '0;
                    idx_d        = '0;
                    if (cfg_fill_words != '0)    state_d = S_FILL;
                    else if (cfg_rd_count != '0) state_d = S_READ;
                    else                         done_d  = 1'b1;
                end
            end
            S_FILL: begin
                if (fill_hs) begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                    if (fill_cnt_d == fill_words_q)
                        state_d = (rd_count_q != '0) ? S_READ : S_DRAIN;
                end
            end
            S_READ: begin
                if (!wt_stall) begin
                    rd_req_d  = 1'b1;
                    rd_addr_d = rd_base_q + idx_q[RD_ADDR_WIDTH-1:0];
                    idx_d     = idx_q + 1'b1;
                    if (idx_d == rd_count_q) begin
                        rd_last_d = 1'b1;
                        state_d   = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Read issued this cycle or tags short of the output stage
                // mean more data is coming; otherwise wt_last is out now.
                if (!rd_req_q && !tag_pend) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            fill_words_q <= '0;
            fill_cnt_q   <= '0;
            rd_base_q    <= '0;
            rd_count_q   <= '0;
            idx_q        <= '0;
            rd_req_q     <= 1'b0;
            rd_addr_q    <= '0;
            rd_last_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_words_q <= fill_words_d;
            fill_cnt_q   <= fill_cnt_d;
            rd_base_q    <= rd_base_d;
            rd_count_q   <= rd_count_d;
            idx_q        <= idx_d;
            rd_req_q     <= rd_req_d;
            rd_addr_q    <= rd_addr_d;
            rd_last_q    <= rd_last_d;
            done_q       <= done_d;
        end
    end

    tag_delay_line #(
        .DEPTH (RD_LAT)
    ) u_tags (
        .clk    (clk),
        .reset  (reset),
        .vld_i  (rd_req_q),
        .last_i (rd_last_q),
        .vld_o  (wt_valid),
        .last_o (wt_last),
        .pend_o (tag_pend)
    );

    assign wt_data        = buf_read_data;
    assign done           = done_q;
    assign buf_read_req   = rd_req_q;
    assign buf_read_addr  = rd_addr_q;
    assign buf_write_req  = fill_hs;
    assign buf_write_data = fill_ready ? fill_data : '0;
    assign buf_write_addr = fill_cnt_q[WR_ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_weight_buffer_sched.sv
// Directed bench for weight_buffer_sched with a behavioural weight buffer
// (4 narrow lanes per wide word, lane 0 in the low bits, 3-cycle reads).
module tb_weight_buffer_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [5:0]  cfg_fill_words;
    logic [6:0]  cfg_rd_base;
    logic [7:0]  cfg_rd_count;
    logic        fill_valid;
    logic        fill_ready;
    logic [63:0] fill_data;
    logic        wt_stall;
    logic        wt_valid;
    logic [15:0] wt_data;
    logic        wt_last;
    logic        done;
    logic        buf_read_req;
    logic [6:0]  buf_read_addr;
    logic [15:0] buf_read_data;
    logic        buf_write_req;
    logic [63:0] buf_write_data;
    logic [4:0]  buf_write_addr;

    weight_buffer_sched dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_fill_words (cfg_fill_words),
        .cfg_rd_base    (cfg_rd_base),
        .cfg_rd_count   (cfg_rd_count),
        .fill_valid     (fill_valid),
        .fill_ready     (fill_ready),
        .fill_data      (fill_data),
        .wt_stall       (wt_stall),
        .wt_valid       (wt_valid),
        .wt_data        (wt_data),
        .wt_last        (wt_last),
        .done           (done),
        .buf_read_req   (buf_read_req),
        .buf_read_addr  (buf_read_addr),
        .buf_read_data  (buf_read_data),
        .buf_write_req  (buf_write_req),
        .buf_write_data (buf_write_data),
        .buf_write_addr (buf_write_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural weight buffer.
    logic [15:0] mem [0:127];
    logic [15:0] rdp [0:2];
    always @(posedge clk) begin
        if (buf_write_req)
            for (int k = 0; k < 4; k++) mem[{buf_write_addr, 2'(k)}] <= buf_write_data[16*k +: 16];
        rdp[0] <= mem[buf_read_addr];
        rdp[1] <= rdp[0];
        rdp[2] <= rdp[1];
    end
    assign buf_read_data = rdp[2];

    // Event capture, sampled mid-cycle.
    int          q_vcyc[$];
    logic [15:0] q_data[$];
    int          q_last[$];
    int          q_raddr[$];
    int          q_rcyc[$];
    int          q_waddr[$];
    int          q_wcyc[$];
    int          q_done[$];

    always @(negedge clk) begin
        if (wt_valid) begin
            q_vcyc.push_back(cyc);
            q_data.push_back(wt_data);
            q_last.push_back(int'(wt_last));
        end
        if (buf_read_req) begin
            q_raddr.push_back(int'(buf_read_addr));
            q_rcyc.push_back(cyc);
        end
        if (buf_write_req) begin
            q_waddr.push_back(int'(buf_write_addr));
            q_wcyc.push_back(cyc);
        end
        if (done) q_done.push_back(cyc);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic clear_q();
        q_vcyc.delete(); q_data.delete(); q_last.delete();
        q_raddr.delete(); q_rcyc.delete();
        q_waddr.delete(); q_wcyc.delete(); q_done.delete();
    endtask

    // Call at #1 after a rising edge; returns the acceptance cycle.
    task automatic start_job(input int fw, input int base, input int cnt, output int t);
        cfg_fill_words = 6'(fw);
        cfg_rd_base    = 7'(base);
        cfg_rd_count   = 8'(cnt);
        cfg_valid      = 1'b1;
        t              = cyc;
        @(posedge clk); #1;
        cfg_valid      = 1'b0;
    endtask

    // Word n carries n in each of its 4 lanes.
    task automatic feed(input int nwords, input bit toggle);
        for (int n = 0; n < nwords; n++) begin
            int g;
            fill_valid = 1'b1;
            fill_data  = {4{16'(n)}};
            g = 0;
            while (!fill_ready && g < 50) begin
                @(posedge clk); #1; g++;
            end
            @(posedge clk); #1;
            if (toggle) begin
                fill_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        fill_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int g;
        g = 0;
        while (q_done.size() == 0 && g < budget) begin
            @(posedge clk); #1; g++;
        end
        chk({tag, "_done_seen"}, int'(q_done.size() > 0), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_reads(input int n);
        int g;
        g = 0;
        while (q_raddr.size() < n && g < 200) begin
            @(negedge clk); g++;
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_data(input string tag, input int base, input int cnt);
        chk({tag, "_nvalid"}, q_data.size(), cnt);
        if (q_data.size() == cnt) begin
            int nl;
            nl = 0;
            for (int k = 0; k < cnt; k++) begin
                chk($sformatf("%s_data%0d", tag, k), int'(q_data[k]), ((base + k) % 128) / 4);
                nl += q_last[k];
            end
            chk({tag, "_nlast"}, nl, 1);
            chk({tag, "_last_pos"}, q_last[cnt-1], 1);
            if (q_done.size() > 0)
                chk({tag, "_done_cyc"}, q_done[0], q_vcyc[cnt-1] + 1);
        end
    endtask

    initial begin
        int t;
        int s;
        int ngap;
        int gapsz;
        int inst;
        int wrap_addr [4];

        reset = 1'b1; cfg_valid = 1'b0; cfg_fill_words = '0; cfg_rd_base = '0;
        cfg_rd_count = '0; fill_valid = 1'b0; fill_data = '0; wt_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        chk("rst_fill_ready", int'(fill_ready), 0);
        chk("rst_wt_valid", int'(wt_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_read_req", int'(buf_read_req), 0);
        chk("rst_write_req", int'(buf_write_req), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Full job: 32 wide words, 128 narrow reads.
        clear_q();
        start_job(32, 0, 128, t);
        chk("full_fill_ready", int'(fill_ready), 1);
        feed(32, 1'b0);
        wait_done("full", 400);
        chk("full_nwr", q_waddr.size(), 32);
        chk_data("full", 0, 128);
        if (q_vcyc.size() == 128) chk("full_span", q_vcyc[127] - q_vcyc[0], 127);
        if (q_rcyc.size() > 0 && q_wcyc.size() == 32) begin
            chk("full_rd_after_wr", int'(q_rcyc[0] > q_wcyc[31]), 1);
            chk("full_first_lat", q_vcyc[0] - q_rcyc[0], 3);
        end

        // Address wrap.
        clear_q();
        start_job(0, 126, 4, t);
        wait_done("wrap", 100);
        wrap_addr = '{126, 127, 0, 1};
        chk("wrap_nrd", q_raddr.size(), 4);
        if (q_raddr.size() == 4)
            for (int k = 0; k < 4; k++) chk($sformatf("wrap_addr%0d", k), q_raddr[k], wrap_addr[k]);
        chk_data("wrap", 126, 4);
        chk("wrap_nwr", q_waddr.size(), 0);

        // Five-cycle stall mid-READ.
        clear_q();
        start_job(0, 0, 20, t);
        wait_reads(6);
        s = cyc;
        wt_stall = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        wt_stall = 1'b0;
        wait_done("stall", 200);
        chk("stall_nrd", q_rcyc.size(), 20);
        ngap = 0; gapsz = 0;
        for (int k = 1; k < q_rcyc.size(); k++)
            if (q_rcyc[k] - q_rcyc[k-1] != 1) begin
                ngap++;
                gapsz = q_rcyc[k] - q_rcyc[k-1] - 1;
            end
        chk("stall_ngap", ngap, 1);
        chk("stall_gap", gapsz, 5);
        inst = 0;
        foreach (q_vcyc[k]) if (q_vcyc[k] >= s + 1 && q_vcyc[k] <= s + 5) inst++;
        chk("stall_inflight_le_lat", int'(inst <= 3), 1);
        chk_data("stall", 0, 20);

        // No fill, five reads.
        clear_q();
        start_job(0, 40, 5, t);
        wait_done("nofill", 100);
        chk("nofill_nwr", q_waddr.size(), 0);
        chk("nofill_nrd", q_raddr.size(), 5);
        chk_data("nofill", 40, 5);

        // Fill only.
        clear_q();
        start_job(3, 0, 0, t);
        feed(3, 1'b0);
        wait_done("fillonly", 100);
        chk("fillonly_nwr", q_waddr.size(), 3);
        if (q_waddr.size() == 3) chk("fillonly_addr2", q_waddr[2], 2);
        chk("fillonly_nvalid", q_data.size(), 0);
        chk("fillonly_nrd", q_raddr.size(), 0);

        // Empty job.
        clear_q();
        start_job(0, 0, 0, t);
        wait_done("empty", 20);
        if (q_done.size() > 0) chk("empty_done_cyc", q_done[0] - t, 1);
        chk("empty_ndone", q_done.size(), 1);
        chk("empty_nrd", q_raddr.size(), 0);

        // Fill backpressure, with a stray descriptor offered throughout.
        clear_q();
        start_job(4, 0, 0, t);
        cfg_fill_words = 6'd0; cfg_rd_base = 7'd0; cfg_rd_count = 8'd0;
        cfg_valid = 1'b1;
        feed(4, 1'b1);
        cfg_valid = 1'b0;
        wait_done("bp", 100);
        chk("bp_nwr", q_waddr.size(), 4);
        if (q_waddr.size() == 4) begin
            for (int k = 0; k < 4; k++) chk($sformatf("bp_addr%0d", k), q_waddr[k], k);
            chk("bp_wr_spacing", q_wcyc[3] - q_wcyc[0], 6);
        end
        chk("bp_ndone", q_done.size(), 1);

        // Reset with reads in flight.
        clear_q();
        start_job(0, 0, 20, t);
        wait_reads(4);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        clear_q();
        chk("rstmid_cfg_ready", int'(cfg_ready), 1);
        chk("rstmid_fill_ready", int'(fill_ready), 0);
        repeat (10) @(posedge clk);
        #1;
        chk("rstmid_nvalid", q_data.size(), 0);
        chk("rstmid_nrd", q_raddr.size(), 0);
        chk("rstmid_ndone", q_done.size(), 0);

        clear_q();
        start_job(0, 8, 4, t);
        wait_done("post", 100);
        chk_data("post", 8, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
